// File: rtl/dmem_if_pkg.sv
// Shared encodings for the data-memory access controller: access sizes,
// controller FSM states and the RAM depth.
package dmem_if_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int RAM_DEPTH = 128;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_RD_WAIT,
      ST_WR,
      ST_RMW_RD,
      ST_RMW_MRG,
      ST_RMW_WR,
      ST_ERR
   } state_t;

   // Encoding 2'b11 is handled as a word access.
   function automatic logic is_word(input logic [1:0] size);
      return size[1];
   endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/response bus between the MIPS MEM stage (master) and the
// data-memory access controller (slave).
interface dmem_access_ctrl_if;

   // Handshake: a request is taken in the cycle where req_valid && req_ready;
   // req_* are don't-care in every other cycle. rsp_valid is a one-cycle pulse
   // that carries rsp_rdata/rsp_err and is not back-pressured.
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte/half lane logic: extracts and extends load data and
// merges store data into a read word. Used by both the load and RMW paths.
module dmem_lane_align
   import dmem_if_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [1:0]  i_lo,
   input  logic [31:0] i_rdata,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load,
   output logic [31:0] o_merge
);

   logic [4:0]  w_bsh;
   logic [4:0]  w_hsh;
   logic [31:0] w_bshifted;
   logic [31:0] w_hshifted;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Big-endian puts offset 0 in the most significant lane.
   assign w_bsh = BIG_ENDIAN ? {~i_lo, 3'b000} : {i_lo, 3'b000};
   assign w_hsh = BIG_ENDIAN ? {~i_lo[1], 4'b0000} : {i_lo[1], 4'b0000};

   assign w_bshifted = i_rdata >> w_bsh;
   assign w_hshifted = i_rdata >> w_hsh;
   assign w_byte     = w_bshifted[7:0];
   assign w_half     = w_hshifted[15:0];

   always_comb begin
      o_load  = i_rdata;
      o_merge = i_wdata;
      case (i_size)
         SZ_BYTE: begin
            o_load  = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            o_merge = (i_rdata & ~(32'h0000_00FF << w_bsh)) |
                      ({24'h0, i_wdata[7:0]} << w_bsh);
         end
         SZ_HALF: begin
            o_load  = {{16{~i_unsigned & w_half[15]}}, w_half};
            o_merge = (i_rdata & ~(32'h0000_FFFF << w_hsh)) |
                      ({16'h0, i_wdata[15:0]} << w_hsh);
         end
         default: begin
            o_load  = i_rdata;
            o_merge = i_wdata;
         end
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Requester side of the 128x32 single-port data RAM: loads, word stores and
// read-modify-write sub-word stores. Optional macro: ALIGN_CHECK_EN.
module dmem_access_ctrl
   import dmem_if_pkg::*;
#(
   parameter int ADDR_W     = 7,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic              clka,
   input  logic              rsta_n,
   dmem_access_ctrl_if.slave bus,
   output logic              ram_wea,
   output logic [ADDR_W-1:0] ram_addra,
   output logic [31:0]       ram_dina,
   input  logic [31:0]       ram_douta,
   output state_t            dbg_state
);

   state_t              r_state;
   state_t              w_next;
   logic                r_we;
   logic [1:0]          r_size;
   logic                r_unsigned;
   logic [1:0]          r_lo;
   logic [ADDR_W-1:0]   r_idx;
   logic [31:0]         r_dina;
   logic                r_rsp_valid;
   logic [31:0]         r_rsp_rdata;
   logic                r_rsp_err;

   logic                w_accept;
   logic                w_misalign;
   logic                w_wr;
   logic                w_rsp_valid;
   logic [31:0]         w_rsp_rdata;
   logic                w_rsp_err;
   logic [31:0]         w_load;
   logic [31:0]         w_merge;
   logic                w_unused;

   assign w_unused = ^{bus.req_addr[31:ADDR_W+2], r_we};

`ifdef ALIGN_CHECK_EN
   always_comb begin
      w_misalign = 1'b0;
      case (bus.req_size)
         SZ_BYTE: w_misalign = 1'b0;
         SZ_HALF: w_misalign = bus.req_addr[0];
         default: w_misalign = (bus.req_addr[1:0] != 2'b00);
      endcase
   end
`else
   assign w_misalign = 1'b0;
`endif

   assign w_accept = bus.req_valid && (r_state == ST_IDLE);

   dmem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .i_lo       (r_lo),
      .i_rdata    (ram_douta),
      .i_wdata    (r_dina),
      .o_load     (w_load),
      .o_merge    (w_merge)
   );

   always_comb begin
      w_next      = r_state;
      w_wr        = 1'b0;
      w_rsp_valid = 1'b0;
      w_rsp_rdata = 32'h0;
      w_rsp_err   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_misalign)                   w_next = ST_ERR;
               else if (!bus.req_we)             w_next = ST_RD;
               else if (is_word(bus.req_size))   w_next = ST_WR;
               else                              w_next = ST_RMW_RD;
            end
         end
         ST_RD:      w_next = ST_RD_WAIT;
         ST_RD_WAIT: begin
            w_next      = ST_IDLE;
            w_rsp_valid = 1'b1;
            w_rsp_rdata = w_load;
         end
         ST_WR: begin
            w_next      = ST_IDLE;
            w_wr        = 1'b1;
            w_rsp_valid = 1'b1;
         end
         ST_RMW_RD:  w_next = ST_RMW_MRG;
         ST_RMW_MRG: w_next = ST_RMW_WR;
         ST_RMW_WR: begin
            w_next      = ST_IDLE;
            w_wr        = 1'b1;
            w_rsp_valid = 1'b1;
         end
         ST_ERR: begin
            w_next      = ST_IDLE;
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b1;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clka) begin
      if (!rsta_n) begin
         r_state     <= ST_IDLE;
         r_we        <= 1'b0;
         r_size      <= SZ_WORD;
         r_unsigned  <= 1'b0;
         r_lo        <= 2'b00;
         r_idx       <= '0;
         r_dina      <= 32'h0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'h0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_rdata <= w_rsp_rdata;
         r_rsp_err   <= w_rsp_err;
         // Misaligned requests never touch the RAM, so addra keeps its value.
         if (w_accept && !w_misalign) begin
            r_we       <= bus.req_we;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_lo       <= bus.req_addr[1:0];
            r_idx      <= bus.req_addr[ADDR_W+1:2];
            r_dina     <= bus.req_wdata;
         end else if (r_state == ST_RMW_MRG) begin
            r_dina     <= w_merge;
         end
      end
   end

   // Reset gates the write strobe combinationally so an aborted RMW never lands.
   assign ram_wea   = rsta_n && w_wr;
   assign ram_addra = rsta_n ? r_idx : '0;
   assign ram_dina  = rsta_n ? r_dina : 32'h0;

   assign bus.req_ready = rsta_n && (r_state == ST_IDLE);
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl with a behavioural 128x32 RAM
// (one-cycle read latency) and a queue-based response scoreboard.
module tb_dmem_access_ctrl;
   import dmem_if_pkg::*;

   logic        clka;
   logic        rsta_n;
   logic        ram_wea;
   logic [6:0]  ram_addra;
   logic [31:0] ram_dina;
   logic [31:0] ram_douta;
   state_t      dbg_state;

   logic [31:0] mem [0:RAM_DEPTH-1];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int busy_until = -1;

   logic [31:0] exp_q[$];
   logic        exp_err_q[$];
   int          exp_cyc_q[$];

   logic [31:0] m_rd;
   logic        m_err;
   int          m_cyc;

   dmem_access_ctrl_if bus ();

   dmem_access_ctrl #(.ADDR_W(7), .BIG_ENDIAN(1'b1)) dut (
      .clka      (clka),
      .rsta_n    (rsta_n),
      .bus       (bus),
      .ram_wea   (ram_wea),
      .ram_addra (ram_addra),
      .ram_dina  (ram_dina),
      .ram_douta (ram_douta),
      .dbg_state (dbg_state)
   );

   // clock / reset, cycle counter and RAM model
   initial clka = 1'b0;
   always #5 clka = ~clka;

   always @(posedge clka) cyc <= cyc + 1;

   initial begin
      for (int i = 0; i < RAM_DEPTH; i++) mem[i] = 32'h0;
   end

   always @(posedge clka) begin
      if (ram_wea) mem[ram_addra] <= ram_dina;
      ram_douta <= mem[ram_addra];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: response scoreboard and ready tracking
   always @(negedge clka) begin
      if (rsta_n) begin
         chk("req_ready", 32'(bus.req_ready), 32'(cyc > busy_until));
         if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
            end else begin
               m_rd  = exp_q.pop_front();
               m_err = exp_err_q.pop_front();
               m_cyc = exp_cyc_q.pop_front();
               chk("rsp_rdata", bus.rsp_rdata, m_rd);
               chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
               chk("rsp_cycle", 32'(cyc), 32'(m_cyc));
            end
         end
      end
   end

   // driver tasks
   task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int lat, input logic exp_wea);
      logic [6:0] prev_addra;
      int t;
      int n;
      n = 0;
      @(negedge clka);
      while (!bus.req_ready && n < 50) begin
         @(negedge clka);
         n++;
      end
      if (!bus.req_ready) begin
         chk("ready_timeout", 32'(bus.req_ready), 32'h1);
         return;
      end
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wd;
      t          = cyc;
      prev_addra = ram_addra;
      exp_q.push_back(exp_rd);
      exp_err_q.push_back(exp_err);
      exp_cyc_q.push_back(t + lat);
      @(posedge clka);
      #1;
      bus.req_valid = 1'b0;
      bus.req_wdata = 32'hBAD0_BAD0;
      bus.req_addr  = 32'hFFFF_FFFF;
      busy_until    = t + lat - 1;
      @(negedge clka);
      chk("wea_t1", 32'(ram_wea), 32'(exp_wea));
      if (exp_err) chk("addra_hold", 32'(ram_addra), 32'(prev_addra));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clka);
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("rsp_timeout", 32'(exp_q.size()), 32'h0);
         exp_q.delete();
         exp_err_q.delete();
         exp_cyc_q.delete();
      end
   endtask

   initial begin
      rsta_n           = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = SZ_WORD;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;

      // reset state
      repeat (2) @(posedge clka);
      @(negedge clka);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_addra", 32'(ram_addra), 32'h0);
      chk("rst_dina", ram_dina, 32'h0);
      chk("rst_wea", 32'(ram_wea), 32'h0);
      chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      busy_until = -1;
      rsta_n = 1'b1;

      // word store then word load
      do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
      do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b0);
      do_req(1'b0, 2'b11,   1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b0);
      wait_idle();
      chk("mem_0x10", mem[4], 32'hDEADBEEF);

      // byte RMW and byte loads, big-endian lanes
      do_req(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 2, 1'b1);
      do_req(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h000000AA, 32'h0, 1'b0, 4, 1'b0);
      wait_idle();
      chk("mem_byte_rmw", mem[8], 32'h11AA3344);
      do_req(1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, 32'hFFFFFFAA, 1'b0, 3, 1'b0);
      do_req(1'b0, SZ_BYTE, 1'b1, 32'h21, 32'h0, 32'h000000AA, 1'b0, 3, 1'b0);
      do_req(1'b0, SZ_BYTE, 1'b1, 32'h23, 32'h0, 32'h00000044, 1'b0, 3, 1'b0);
      do_req(1'b0, SZ_BYTE, 1'b0, 32'h20, 32'h0, 32'h00000011, 1'b0, 3, 1'b0);

      // half RMW over zero and half loads
      do_req(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 2, 1'b1);
      do_req(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h00008001, 32'h0, 1'b0, 4, 1'b0);
      wait_idle();
      chk("mem_half_rmw", mem[8], 32'h00008001);
      do_req(1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, 3, 1'b0);
      do_req(1'b0, SZ_HALF, 1'b1, 32'h20, 32'h0, 32'h00000000, 1'b0, 3, 1'b0);

      // address wrap, back-to-back
      do_req(1'b1, SZ_WORD, 1'b0, 32'h200, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b1);
      do_req(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1'b0);
      do_req(1'b0, SZ_WORD, 1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1'b0);
      wait_idle();
      chk("mem_wrap", mem[0], 32'hCAFEF00D);

      // reset asserted during the RMW write cycle
      do_req(1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h00000055, 32'h0, 1'b0, 4, 1'b0);
      @(posedge clka);
      @(posedge clka);
      #1;
      rsta_n = 1'b0;
      exp_q.delete();
      exp_err_q.delete();
      exp_cyc_q.delete();
      @(negedge clka);
      chk("abort_state", 32'(dbg_state), 32'(ST_RMW_WR));
      chk("abort_wea", 32'(ram_wea), 32'h0);
      chk("abort_rsp", 32'(bus.rsp_valid), 32'h0);
      @(negedge clka);
      chk("abort_rsp_after", 32'(bus.rsp_valid), 32'h0);
      chk("abort_idle", 32'(dbg_state), 32'(ST_IDLE));
      chk("abort_ready_low", 32'(bus.req_ready), 32'h0);
      busy_until = -1;
      rsta_n = 1'b1;
      chk("abort_mem", mem[4], 32'hDEADBEEF);
      @(negedge clka);
      chk("abort_ready_high", 32'(bus.req_ready), 32'h1);
      do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b0);

      // misaligned word load
`ifdef ALIGN_CHECK_EN
      do_req(1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 2, 1'b0);
      do_req(1'b0, SZ_HALF, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 2, 1'b0);
`else
      do_req(1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b0);
      do_req(1'b0, SZ_HALF, 1'b1, 32'h11, 32'h0, 32'h0000DEAD, 1'b0, 3, 1'b0);
`endif
      wait_idle();
      repeat (3) @(negedge clka);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
